ecpri_tx: RTL and testbench
===========================

ECPRI_TX -- requirements
Module: ecpri_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 8, byte-lane width of all data ports.
REQ-002 Parameter ADDR_WIDTH, default 16, width of all RAM address ports.
REQ-003 Parameter ECPRI_ETYPE, default 16'hAEFE, Ethertype written to frame bytes 12-13.
REQ-004 clk  in  1  single clock; all logic on posedge.
REQ-005 reset  in  1  asynchronous, active-high; clears all state.
REQ-006 send_read_resp  in  1  one-cycle request for a read-response frame.
REQ-007 send_write_resp  in  1  one-cycle request for a write-response frame.
REQ-008 resp_payload_len  in  DATA_WIDTH  read-response payload byte count N (0-255), sampled with the request.
REQ-009 addr_0 out ADDR_WIDTH, oe_0 out 1, data_0 in DATA_WIDTH: received Ethernet header RAM read port.
REQ-010 addr_2 out ADDR_WIDTH, oe_2 out 1, data_2 in DATA_WIDTH: payload RAM read port.
REQ-011 addr_3 out ADDR_WIDTH, data_3 out DATA_WIDTH, we_3 out 1: TX frame buffer write port.
REQ-012 tx_busy out 1, tx_done out 1, tx_len out 16, req_overflow out 1: status.

Function
REQ-013 Both read ports have 1-cycle synchronous latency: data valid the cycle after addr/oe.
REQ-014 FSM states: IDLE, MAC_SWAP, ETYPE, ECPRI_HDR, RMA_HDR, PAYLOAD, DONE; IDLE->MAC_SWAP on accepted request; strictly sequential thereafter; DONE->IDLE (or ->MAC_SWAP if a request is pending).
REQ-015 Frame bytes 0-5 = header RAM addr 6-11; bytes 6-11 = header RAM addr 0-5 (MAC swap).
REQ-016 Bytes 12-13 = ECPRI_ETYPE high then low byte.
REQ-017 Bytes 14-17 = 8'h10, 8'h04, eCPRI payload size (4+P) as 16-bit big-endian; P=N for read, 0 for write.
REQ-018 Bytes 18-21 = RMA id 8'h00, 8'h02 (read resp) or 8'h12 (write resp), P as 16-bit big-endian.
REQ-019 Bytes 22..21+P = payload RAM addr 0..P-1, in order.
REQ-020 Frame byte k written to addr_3=k with we_3=1; writes on consecutive cycles, no gaps.
REQ-021 First we_3 occurs exactly 2 cycles after the request-sampling edge; tx_busy=1 from the edge after sampling until tx_done.
REQ-022 tx_done pulses 1 cycle, the cycle after the last write; tx_len = 22+P, valid from tx_done until next tx_done.
REQ-023 oe_0/oe_2 asserted only when a read is issued; we_3 low outside frame writes.
REQ-024 N captured at acceptance; changes to resp_payload_len mid-frame have no effect.
REQ-025 Both requests in the same cycle: read served first, write latched pending.
REQ-026 Request arriving while busy: latched in a per-type pending flag; served after current DONE, read pending before write pending.
REQ-027 Request of a type already pending: dropped; req_overflow set sticky until reset.
REQ-028 Pending read latches its own N at arrival.
REQ-029 N=0 read: PAYLOAD skipped, 22-byte frame, payload RAM never read.

Reset
REQ-030 On reset: state IDLE, pending flags 0, all outputs 0 (addr_*, data_3, oe_*, we_3, tx_busy, tx_done, tx_len, req_overflow).
REQ-031 Reset mid-frame aborts immediately; no further we_3; partial frame not completed after release.
REQ-032 Requests coincident with reset asserted are ignored.

Verification
REQ-033 Header RAM 0-5=01..06, 6-11=11..16, read req N=4, payload AA BB CC DD -> 26 writes: 11..16,01..06,AE,FE,10,04,00,08,00,02,00,04,AA,BB,CC,DD; tx_len=26.
REQ-034 Write req -> 22 writes, bytes 14-21 = 10,04,00,04,00,12,00,00; tx_done 1 cycle after addr_3=21.
REQ-035 Simultaneous read (N=2) and write -> 24-byte read frame, then 22-byte write frame; two tx_done pulses; req_overflow=0.
REQ-036 Two write reqs during a busy read frame -> one write frame follows; req_overflow=1.
REQ-037 Read N=0 -> 22-byte frame, oe_2 never asserted, tx_len=22.
REQ-038 Reset asserted at frame byte 10 -> outputs 0 next edge, no we_3 after release until new request.

Source files
------------

// File: rtl/ecpri_tx.sv
// eCPRI response frame builder: copies a MAC-swapped Ethernet header, the eCPRI and
// RMA headers and an optional payload into a TX frame buffer, one byte per cycle.
module ecpri_tx #(
  parameter int          DATA_WIDTH  = 8,
  parameter int          ADDR_WIDTH  = 16,
  parameter logic [15:0] ECPRI_ETYPE = 16'hAEFE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  send_read_resp,
  input  logic                  send_write_resp,
  input  logic [DATA_WIDTH-1:0] resp_payload_len,
  output logic [ADDR_WIDTH-1:0] addr_0,
  output logic                  oe_0,
  input  logic [DATA_WIDTH-1:0] data_0,
  output logic [ADDR_WIDTH-1:0] addr_2,
  output logic                  oe_2,
  input  logic [DATA_WIDTH-1:0] data_2,
  output logic [ADDR_WIDTH-1:0] addr_3,
  output logic [DATA_WIDTH-1:0] data_3,
  output logic                  we_3,
  output logic                  tx_busy,
  output logic                  tx_done,
  output logic [15:0]           tx_len,
  output logic                  req_overflow
);
  // Handshake: requests are one-cycle strobes sampled on posedge; tx_done is a one-cycle
  // strobe; we_3 marks each valid frame-buffer write (no backpressure on any port).
  typedef enum logic [2:0] {IDLE, MAC_SWAP, ETYPE, ECPRI_HDR, RMA_HDR, PAYLOAD, DONE} state_t;
  typedef enum logic [1:0] {SRC_CONST, SRC_HDR, SRC_PAY} src_t;

  state_t                state;
  logic [15:0]           bidx;
  logic [DATA_WIDTH-1:0] cur_p, pend_n;
  logic                  cur_rd, pend_rd, pend_wr;

  // Two tag stages line up each issued byte with the 1-cycle RAM read latency.
  logic                  s1_v, s1_last, s2_v, s2_last, w_last;
  src_t                  s1_src, s2_src;
  logic [15:0]           s1_idx, s2_idx;
  logic [DATA_WIDTH-1:0] s1_const, s2_const;

  logic                  can_start, rd_avail, wr_avail, start_rd, start_wr;
  logic [DATA_WIDTH-1:0] start_n, const_byte;
  logic [15:0]           plen, esize, last_idx;

  always_comb begin
    can_start = (state == IDLE) || (state == DONE);
    rd_avail  = pend_rd || send_read_resp;
    wr_avail  = pend_wr || send_write_resp;
    start_rd  = can_start && rd_avail;
    start_wr  = can_start && !rd_avail && wr_avail;
    start_n   = pend_rd ? pend_n : resp_payload_len;
    plen      = 16'(cur_p);
    esize     = plen + 16'd4;
    last_idx  = plen + 16'd21;
    const_byte = '0;
    case (bidx[4:0])
      5'd12:   const_byte = DATA_WIDTH'(ECPRI_ETYPE[15:8]);
      5'd13:   const_byte = DATA_WIDTH'(ECPRI_ETYPE[7:0]);
      5'd14:   const_byte = DATA_WIDTH'(8'h10);
      5'd15:   const_byte = DATA_WIDTH'(8'h04);
      5'd16:   const_byte = DATA_WIDTH'(esize[15:8]);
      5'd17:   const_byte = DATA_WIDTH'(esize[7:0]);
      5'd19:   const_byte = cur_rd ? DATA_WIDTH'(8'h02) : DATA_WIDTH'(8'h12);
      5'd20:   const_byte = DATA_WIDTH'(plen[15:8]);
      5'd21:   const_byte = DATA_WIDTH'(plen[7:0]);
      default: const_byte = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      bidx         <= '0;
      cur_p        <= '0;
      pend_n       <= '0;
      cur_rd       <= 1'b0;
      pend_rd      <= 1'b0;
      pend_wr      <= 1'b0;
      s1_v         <= 1'b0;
      s1_last      <= 1'b0;
      s1_src       <= SRC_CONST;
      s1_idx       <= '0;
      s1_const     <= '0;
      s2_v         <= 1'b0;
      s2_last      <= 1'b0;
      s2_src       <= SRC_CONST;
      s2_idx       <= '0;
      s2_const     <= '0;
      w_last       <= 1'b0;
      addr_0       <= '0;
      oe_0         <= 1'b0;
      addr_2       <= '0;
      oe_2         <= 1'b0;
      addr_3       <= '0;
      data_3       <= '0;
      we_3         <= 1'b0;
      tx_busy      <= 1'b0;
      tx_done      <= 1'b0;
      tx_len       <= '0;
      req_overflow <= 1'b0;
    end else begin
      oe_0     <= 1'b0;
      oe_2     <= 1'b0;
      s1_v     <= 1'b0;
      s1_last  <= 1'b0;
      s2_v     <= s1_v;
      s2_last  <= s1_last;
      s2_src   <= s1_src;
      s2_idx   <= s1_idx;
      s2_const <= s1_const;
      we_3     <= s2_v;
      w_last   <= s2_v && s2_last;
      if (s2_v) begin
        addr_3 <= ADDR_WIDTH'(s2_idx);
        case (s2_src)
          SRC_HDR: data_3 <= data_0;
          SRC_PAY: data_3 <= data_2;
          default: data_3 <= s2_const;
        endcase
      end
      tx_done <= w_last;
      if (w_last) begin
        tx_len <= 16'(addr_3) + 16'd1;
        if (state == IDLE) tx_busy <= 1'b0;
      end

      // A pending flag being served this cycle frees its slot for a new arrival.
      if (start_rd) begin
        pend_rd <= pend_rd && send_read_resp;
        if (pend_rd && send_read_resp) pend_n <= resp_payload_len;
      end else if (send_read_resp) begin
        if (pend_rd) req_overflow <= 1'b1;
        else begin
          pend_rd <= 1'b1;
          pend_n  <= resp_payload_len;
        end
      end
      if (start_wr) begin
        pend_wr <= pend_wr && send_write_resp;
      end else if (send_write_resp) begin
        if (pend_wr) req_overflow <= 1'b1;
        else pend_wr <= 1'b1;
      end

      case (state)
        IDLE, DONE: begin
          if (start_rd || start_wr) begin
            cur_rd  <= start_rd;
            cur_p   <= start_rd ? start_n : '0;
            addr_0  <= ADDR_WIDTH'(6);
            oe_0    <= 1'b1;
            s1_v    <= 1'b1;
            s1_src  <= SRC_HDR;
            s1_idx  <= '0;
            bidx    <= 16'd1;
            tx_busy <= 1'b1;
            state   <= MAC_SWAP;
          end else begin
            state <= IDLE;
          end
        end
        MAC_SWAP: begin
          addr_0 <= (bidx < 16'd6) ? ADDR_WIDTH'(bidx + 16'd6) : ADDR_WIDTH'(bidx - 16'd6);
          oe_0   <= 1'b1;
          s1_v   <= 1'b1;
          s1_src <= SRC_HDR;
          s1_idx <= bidx;
          bidx   <= bidx + 16'd1;
          if (bidx == 16'd11) state <= ETYPE;
        end
        ETYPE, ECPRI_HDR, RMA_HDR: begin
          s1_v     <= 1'b1;
          s1_src   <= SRC_CONST;
          s1_const <= const_byte;
          s1_idx   <= bidx;
          s1_last  <= (bidx == 16'd21) && (plen == 16'd0);
          bidx     <= bidx + 16'd1;
          if (bidx == 16'd13) state <= ECPRI_HDR;
          if (bidx == 16'd17) state <= RMA_HDR;
          if (bidx == 16'd21) state <= (plen == 16'd0) ? DONE : PAYLOAD;
        end
        PAYLOAD: begin
          addr_2  <= ADDR_WIDTH'(bidx - 16'd22);
          oe_2    <= 1'b1;
          s1_v    <= 1'b1;
          s1_src  <= SRC_PAY;
          s1_idx  <= bidx;
          s1_last <= (bidx == last_idx);
          bidx    <= bidx + 16'd1;
          if (bidx == last_idx) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ecpri_tx.sv
// Bench for ecpri_tx: directed requests, expected frame bytes queued by the driver and
// popped by a monitor on every frame-buffer write; tx_len checked on every tx_done.
module tb_ecpri_tx;
  localparam int W = 24;

  logic        clk = 1'b0;
  logic        reset;
  logic        send_read_resp, send_write_resp;
  logic [7:0]  resp_payload_len;
  logic [15:0] addr_0, addr_2, addr_3;
  logic        oe_0, oe_2, we_3;
  logic [7:0]  data_0, data_2, data_3;
  logic        tx_busy, tx_done, req_overflow;
  logic [15:0] tx_len;

  logic [7:0]  hdr_mem [0:255];
  logic [7:0]  pay_mem [0:255];
  logic [7:0]  t1_bytes [26];

  logic [W-1:0] exp_q[$];
  logic [15:0]  len_q[$];
  logic [W-1:0] mon_e;
  logic [15:0]  mon_l;
  logic [15:0]  prev_addr;
  bit           prev_we;
  int           cmp_cnt = 0, err_cnt = 0, done_cnt = 0, oe2_cnt = 0;

  ecpri_tx dut (
    .clk(clk), .reset(reset),
    .send_read_resp(send_read_resp), .send_write_resp(send_write_resp),
    .resp_payload_len(resp_payload_len),
    .addr_0(addr_0), .oe_0(oe_0), .data_0(data_0),
    .addr_2(addr_2), .oe_2(oe_2), .data_2(data_2),
    .addr_3(addr_3), .data_3(data_3), .we_3(we_3),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx_len(tx_len), .req_overflow(req_overflow)
  );

  // clock / RAM models
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (oe_0) data_0 <= hdr_mem[addr_0[7:0]];
    if (oe_2) data_2 <= pay_mem[addr_2[7:0]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    cmp_cnt++;
    if (act !== req) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (reset) begin
      prev_we = 1'b0;
    end else begin
      if (oe_2) oe2_cnt++;
      if (we_3) begin
        if (exp_q.size() == 0) begin
          cmp_cnt++; err_cnt++;
          $display("FAIL unexpected_write: got addr %0d data %0h, expected no write", addr_3, data_3);
        end else begin
          mon_e = exp_q.pop_front();
          chk("frame_byte", {8'h0, addr_3, data_3}, {8'h0, mon_e});
        end
        if (addr_3 != 16'd0) chk("no_gap", {31'd0, prev_we}, 32'd1);
        chk("busy_during_write", {31'd0, tx_busy}, 32'd1);
      end
      if (tx_done) begin
        done_cnt++;
        if (len_q.size() == 0) begin
          cmp_cnt++; err_cnt++;
          $display("FAIL unexpected_done: got tx_done with tx_len %0d, expected none", tx_len);
        end else begin
          mon_l = len_q.pop_front();
          chk("tx_len", {16'd0, tx_len}, {16'd0, mon_l});
          chk("done_after_last", {15'd0, prev_we, prev_addr}, {15'd0, 1'b1, mon_l - 16'd1});
        end
      end
      prev_we   = we_3;
      prev_addr = addr_3;
    end
  end

  // driver tasks
  function automatic void push(input int a, input logic [7:0] d);
    exp_q.push_back({16'(a), d});
  endfunction

  function automatic void push_frame(input bit rd, input int n);
    logic [15:0] p, sz;
    p  = rd ? 16'(n) : 16'd0;
    sz = p + 16'd4;
    for (int k = 0; k < 6; k++) push(k, hdr_mem[6 + k]);
    for (int k = 0; k < 6; k++) push(6 + k, hdr_mem[k]);
    push(12, 8'hAE); push(13, 8'hFE); push(14, 8'h10); push(15, 8'h04);
    push(16, sz[15:8]); push(17, sz[7:0]);
    push(18, 8'h00); push(19, rd ? 8'h02 : 8'h12); push(20, p[15:8]); push(21, p[7:0]);
    for (int i = 0; i < int'(p); i++) push(22 + i, pay_mem[i]);
    len_q.push_back(16'd22 + p);
  endfunction

  task automatic req(input bit rd, input bit wr, input logic [7:0] n, input bit lat);
    @(negedge clk);
    send_read_resp = rd; send_write_resp = wr; resp_payload_len = n;
    @(posedge clk); #1;
    send_read_resp = 1'b0; send_write_resp = 1'b0; resp_payload_len = 8'd9;
    if (lat) begin
      @(posedge clk); #1;
      chk("lat_e1_busy", {31'd0, tx_busy}, 32'd1);
      chk("lat_e1_no_we", {31'd0, we_3}, 32'd0);
      @(posedge clk); #1;
      chk("lat_e2_first_we", {15'd0, we_3, addr_3}, {15'd0, 1'b1, 16'd0});
    end
  endtask

  task automatic wait_idle();
    int t;
    for (t = 0; t < 3000; t++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0 && len_q.size() == 0 && !tx_busy) break;
    end
    chk("idle_timeout", {31'd0, t < 3000}, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_zero();
    chk("rst_rd_addr", {addr_0, addr_2}, 32'd0);
    chk("rst_wr_port", {7'd0, addr_3, data_3, we_3}, 32'd0);
    chk("rst_ctl", {11'd0, oe_0, oe_2, tx_busy, tx_done, req_overflow, tx_len}, 32'd0);
  endtask

  initial begin
    int  d0;
    bit  found;
    reset = 1'b1;
    send_read_resp = 1'b0; send_write_resp = 1'b0; resp_payload_len = 8'd0;
    for (int i = 0; i < 256; i++) begin
      hdr_mem[i] = (i < 6) ? 8'(i + 1) : (i < 12) ? 8'(8'h11 + i - 6) : 8'hEE;
      pay_mem[i] = 8'(8'h40 + i);
    end
    pay_mem[0] = 8'hAA; pay_mem[1] = 8'hBB; pay_mem[2] = 8'hCC; pay_mem[3] = 8'hDD;
    t1_bytes = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h01, 8'h02, 8'h03, 8'h04,
                 8'h05, 8'h06, 8'hAE, 8'hFE, 8'h10, 8'h04, 8'h00, 8'h08, 8'h00, 8'h02,
                 8'h00, 8'h04, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    repeat (3) @(negedge clk);
    check_zero();
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // read N=4, hand-listed bytes; length changed after acceptance
    for (int k = 0; k < 26; k++) push(k, t1_bytes[k]);
    len_q.push_back(16'd26);
    req(1'b1, 1'b0, 8'd4, 1'b1);
    wait_idle();
    chk("t1_len_hold", {16'd0, tx_len}, 32'd26);

    // write response
    push_frame(1'b0, 0);
    req(1'b0, 1'b1, 8'd0, 1'b1);
    wait_idle();

    // simultaneous read N=2 and write
    d0 = done_cnt;
    push_frame(1'b1, 2); push_frame(1'b0, 0);
    req(1'b1, 1'b1, 8'd2, 1'b0);
    wait_idle();
    chk("t3_done_pulses", 32'(done_cnt - d0), 32'd2);
    chk("t3_no_overflow", {31'd0, req_overflow}, 32'd0);

    // requests while busy: write, duplicate write (dropped), read N=3 pending
    push_frame(1'b1, 6); push_frame(1'b1, 3); push_frame(1'b0, 0);
    req(1'b1, 1'b0, 8'd6, 1'b0);
    repeat (3) @(negedge clk);
    req(1'b0, 1'b1, 8'd0, 1'b0);
    req(1'b0, 1'b1, 8'd0, 1'b0);
    req(1'b1, 1'b0, 8'd3, 1'b0);
    wait_idle();
    chk("t4_overflow", {31'd0, req_overflow}, 32'd1);

    // reset clears overflow; read N=0 never touches payload RAM
    @(negedge clk); reset = 1'b1;
    @(negedge clk); check_zero(); reset = 1'b0;
    oe2_cnt = 0;
    push_frame(1'b1, 0);
    req(1'b1, 1'b0, 8'd0, 1'b1);
    wait_idle();
    chk("t5_no_oe2", 32'(oe2_cnt), 32'd0);
    chk("t5_len", {16'd0, tx_len}, 32'd22);

    // reset at frame byte 10, request during reset ignored, no writes after release
    push_frame(1'b1, 4);
    req(1'b1, 1'b0, 8'd4, 1'b0);
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(posedge clk); #1;
      if (we_3 && addr_3 == 16'd10) found = 1'b1;
    end
    chk("t6_reached_byte10", {31'd0, found}, 32'd1);
    reset = 1'b1;
    exp_q.delete(); len_q.delete();
    @(posedge clk); #1;
    check_zero();
    @(negedge clk); send_read_resp = 1'b1;
    @(negedge clk); send_read_resp = 1'b0;
    @(negedge clk); reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("t6_quiet_busy", {31'd0, tx_busy}, 32'd0);
    push_frame(1'b0, 0);
    req(1'b0, 1'b1, 8'd0, 1'b1);
    wait_idle();

    chk("final_queue_empty", 32'(exp_q.size() + len_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule
